state_dump_engine: RTL
======================

// Module: state_dump_engine
// PURPOSE
// - Hardware successor to hierarchical end-of-run dumps: gates the CPU for a programmed cycle count, then streams out
//   register file and a data-memory window through read ports, one word per valid/ready handshake.
// - Sits beside cpu: drives cpu_run (clock-enable/stall), owns spare RF/DMEM read ports, feeds a UART/log sink.
// PARAMETERS
// - XLEN        32   data word width
// - NREGS       32   registers dumped (x0..x(NREGS-1)), 1..32
// - DM_WORDS    32   DMEM words dumped, >=1
// - DM_BASE     0    first DMEM word index dumped
// - DM_AW       10   DMEM word-address width
// - CNT_W       16   run-cycle counter width
// PORTS
// - clk           in   1        clock, all state on rising edge
// - rst           in   1        asynchronous, active-low reset (0 = reset)
// - start         in   1        begin session; sampled only in IDLE
// - run_cycles    in   CNT_W    CPU cycles to run, latched on accepted start
// - cpu_run       out  1        CPU enable; 1 only in RUN
// - rf_raddr      out  5        RF read address (combinational read)
// - rf_rdata      in   XLEN     RF read data, same cycle
// - dm_raddr      out  DM_AW    DMEM word address (combinational read)
// - dm_rdata      in   XLEN     DMEM read data, same cycle
// - out_valid     out  1        dump word available
// - out_ready     in   1        sink accepts word
// - out_data      out  XLEN     dump word
// - out_tag       out  9        {is_mem, index[7:0]}; index = reg number or DM word offset from DM_BASE
// - out_last      out  1        final word of session
// - busy          out  1        state != IDLE and != DONE
// - done          out  1        1 in DONE
// BEHAVIOUR
// - Reset (any time, incl. mid-session): state=IDLE; cpu_run, out_valid, out_last, busy, done = 0; out_data, out_tag,
//   counters = 0; rf_raddr, dm_raddr = 0. Partial output word is discarded.
// - FSM: IDLE -> RUN -> RF -> DM -> DONE -> IDLE.
// - IDLE: start=1 latches run_cycles into cnt; next RUN if run_cycles!=0, else RF directly.
// - RUN: cpu_run=1 for exactly run_cycles consecutive cycles (cnt decrements each cycle); on the cycle cnt==1, next=RF.
// - RF/DM: output register stage. When out_valid=0 or (out_valid & out_ready), load out_data from rdata at current
//   idx, set out_valid=1, tag, advance idx. Throughput 1 word/cycle with out_ready held high.
// - Hold rule: out_valid & !out_ready -> out_data/tag/last/valid held stable; idx and read address frozen.
// - RF order x0..x(NREGS-1) (x0 read as delivered, expected 0); then DM offsets 0..DM_WORDS-1, dm_raddr=DM_BASE+off
//   truncated to DM_AW bits (wraps modulo 2^DM_AW).
// - out_last=1 only with the DM word at offset DM_WORDS-1. Its handshake -> DONE, out_valid=0 next cycle.
// - First dump word is valid the cycle after entering RF (1-cycle latency from RUN end).
// - DONE: done=1, busy=0; start=1 -> accepted as in IDLE (new session). Otherwise stay.
// - start while busy: ignored. out_ready while out_valid=0: no effect.
// - Total words per session = NREGS + DM_WORDS.
// STRUCTURE
// - Shared package dump_pkg: state enum (IDLE, RUN, RF, DM, DONE), TAG_W=9, tag field offsets.
// - One sub-module: dump_out_reg (valid/ready skid-free output register with hold); FSM/counters in top.
// TESTING
// - Reset, start=1 run_cycles=5 -> cpu_run high exactly 5 cycles, then 64 words, tags 0x000..0x01F, 0x100..0x11F.
// - Preload x1=1,x2=2,x3=3,x4=4, DMEM[2]=0x00005678 -> word tag 0x003 = 3; tag 0x102 = 0x00005678; last on 0x11F.
// - out_ready toggled 1,0,0,1 pseudo-random -> no word lost/duplicated, data stable while stalled, order intact.
// - run_cycles=0 -> cpu_run never asserted, first out_valid 2 cycles after start.
// - rst=0 asserted mid-DM dump (after tag 0x105) -> all outputs 0 immediately; new start restarts at tag 0x000.
// - DM_BASE=1020, DM_AW=10, DM_WORDS=8 -> dm_raddr sequence 1020..1023,0..3; start during RF ignored; DONE+start reruns.

Source files
------------

// File: rtl/dump_pkg.sv
// dump_pkg: shared state encoding and output tag layout for the state dump engine.
package dump_pkg;
    typedef enum logic [2:0] {IDLE, RUN, RF, DM, DONE} state_t;
    localparam int TAG_W       = 9;
    localparam int TAG_MEM_BIT = 8;
    localparam int TAG_IDX_W   = 8;
    function automatic logic [TAG_W-1:0] mk_tag(input logic is_mem, input logic [TAG_IDX_W-1:0] idx);
        return {is_mem, idx};
    endfunction
endpackage

// File: rtl/dump_out_reg.sv
// dump_out_reg: valid/ready output register; a loaded word is held until the sink takes it.
//   clk, rst(async, active-low), load (capture din/tin/lin), ready (sink accept),
//   valid/data/tag/last (registered word presented to the sink).
module dump_out_reg
    import dump_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ready,
    input  logic [W-1:0]     din,
    input  logic [TAG_W-1:0] tin,
    input  logic             lin,
    output logic             valid,
    output logic [W-1:0]     data,
    output logic [TAG_W-1:0] tag,
    output logic             last
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
            tag   <= tin;
            last  <= lin;
        end else if (ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
endmodule

// File: rtl/state_dump_engine.sv
// state_dump_engine: runs the CPU for a programmed cycle count, then streams the RF and a DMEM window.
//   start/run_cycles begin a session; cpu_run gates the CPU; rf_*/dm_* are combinational read ports;
//   out_valid/out_ready/out_data/out_tag/out_last stream the dump; busy/done report session state.
module state_dump_engine
    import dump_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int DM_WORDS = 32,
    parameter int DM_BASE  = 0,
    parameter int DM_AW    = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] run_cycles,
    output logic             cpu_run,
    output logic [4:0]       rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic [DM_AW-1:0] dm_raddr,
    input  logic [XLEN-1:0]  dm_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    localparam int IW = 16;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0]    idx;
    logic             rf_end, dm_end, want, issue, drain_done;
    assign rf_end     = idx == IW'(NREGS - 1);
    assign dm_end     = idx == IW'(DM_WORDS - 1);
    // once the last word is in the output register nothing more is issued; we only wait for its handshake
    assign want       = state == RF || (state == DM && !(out_valid && out_last));
    assign issue      = want && (!out_valid || out_ready);
    assign drain_done = state == DM && out_valid && out_ready && out_last;
    assign rf_raddr   = state == RF ? idx[4:0] : '0;
    assign dm_raddr   = state == DM ? DM_AW'(DM_BASE + int'(idx)) : '0;
    assign cpu_run    = state == RUN;
    assign busy       = state == RUN || state == RF || state == DM;
    assign done       = state == DONE;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= run_cycles != '0 ? RUN : RF;
                    cnt   <= run_cycles;
                    idx   <= '0;
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= RF;
                end
                RF: if (issue) begin
                    state <= rf_end ? DM : RF;
                    idx   <= rf_end ? '0 : idx + IW'(1);
                end
                DM: begin
                    if (drain_done) state <= DONE;
                    else if (issue && !dm_end) idx <= idx + IW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    dump_out_reg #(.W(XLEN)) u_out (
        .clk   (clk),
        .rst   (rst),
        .load  (issue),
        .ready (out_ready),
        .din   (state == RF ? rf_rdata : dm_rdata),
        .tin   (mk_tag(state == DM, idx[TAG_IDX_W-1:0])),
        .lin   (state == DM && dm_end),
        .valid (out_valid),
        .data  (out_data),
        .tag   (out_tag),
        .last  (out_last)
    );
endmodule
